// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the highest set bit of vec.
module priority_encoder #(
   parameter int N = 8,
   parameter int M = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] vec,
   output logic [M-1:0] idx,
   output logic         found
);

   // Ascending scan so the last (highest) set bit wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = M'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_arbiter.sv
// Fixed-priority / round-robin arbiter with a registered valid/ready grant.
// One grant is held until accepted, then the arbiter idles for a cycle.
module priority_arbiter
   import arb_pkg::*;
#(
   parameter int N = 8,
   parameter int M = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         mode,
   output logic         gnt_valid,
   input  logic         gnt_ready,
   output logic [M-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot,
   output logic         busy
);

   state_t         state;
   logic           mode_q;     // mode captured with the current grant
   logic [M-1:0]   last_idx;   // last accepted round-robin winner
   logic [N-1:0]   mask;
   logic [N-1:0]   masked;
   logic [M-1:0]   idx_m, idx_u;
   logic           found_m, found_u;
   logic [M-1:0]   win;
   logic [N-1:0]   win_oh;

   // Round-robin mask: only requesters strictly below the last winner.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) mask[i] = (M'(i) < last_idx);
   end

   assign masked = req & mask;

   priority_encoder #(.N(N), .M(M)) u_pe_masked (
      .vec   (masked),
      .idx   (idx_m),
      .found (found_m)
   );

   priority_encoder #(.N(N), .M(M)) u_pe_full (
      .vec   (req),
      .idx   (idx_u),
      .found (found_u)
   );

   // Winner select: masked hit in RR mode, otherwise wrap to the plain highest.
   always_comb begin
      win = (mode == MODE_RR && found_m) ? idx_m : idx_u;
      win_oh = '0;
      for (int i = 0; i < N; i++) win_oh[i] = (win == M'(i));
   end

   // Two-state grant FSM; every output is a register so req never reaches them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_q     <= MODE_FIXED;
         last_idx   <= '0;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found_u) begin
                  state      <= GRANT;
                  mode_q     <= mode;
                  gnt_valid  <= 1'b1;
                  gnt_idx    <= win;
                  gnt_onehot <= win_oh;
                  busy       <= 1'b1;
               end
            end
            GRANT: begin
               // Grant is sticky: only the handshake ends it.
               if (gnt_ready) begin
                  state      <= IDLE;
                  gnt_valid  <= 1'b0;
                  gnt_onehot <= '0;
                  busy       <= 1'b0;
                  if (mode_q == MODE_RR) last_idx <= gnt_idx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter: an N=8 and an N=5 instance share
// stimulus; a behavioural model predicts grants, a monitor checks them.
module tb_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode = 1'b0;
   logic       gnt_ready = 1'b0;
   logic [7:0] req8 = '0;
   logic [4:0] req5 = '0;

   logic       v8, busy8, v5, busy5;
   logic [2:0] idx8, idx5;
   logic [7:0] oh8;
   logic [4:0] oh5;

   int n_checks = 0;
   int n_fail   = 0;

   // model state per instance (0: N=8, 1: N=5)
   bit mbusy [2];
   bit mmode [2];
   int midx  [2];
   int mlast [2];
   int q0[$], q1[$];
   int glog0[$], glog1[$];

   // monitor state
   bit pv  [2];
   int cur [2];

   priority_arbiter #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode),
      .gnt_valid(v8), .gnt_ready(gnt_ready), .gnt_idx(idx8),
      .gnt_onehot(oh8), .busy(busy8)
   );

   priority_arbiter #(.N(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode),
      .gnt_valid(v5), .gnt_ready(gnt_ready), .gnt_idx(idx5),
      .gnt_onehot(oh5), .busy(busy5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, got, exp, $time);
      end
   endtask

   // Reference rule: highest requester below last (RR), else highest overall.
   function automatic int ref_win(input logic [7:0] rq, input int n, input bit md, input int last);
      int hi = -1;
      int below = -1;
      for (int i = 0; i < n; i++) begin
         if (rq[i]) begin
            hi = i;
            if (i < last) below = i;
         end
      end
      return (md && below >= 0) ? below : hi;
   endfunction

   task automatic model_step(input int d, input logic [7:0] rq, input bit md, input bit rdy);
      int w;
      if (!mbusy[d]) begin
         if (rq != 0) begin
            w = ref_win(rq, (d == 0) ? 8 : 5, md, mlast[d]);
            if (d == 0) q0.push_back(w); else q1.push_back(w);
            mbusy[d] = 1'b1;
            mmode[d] = md;
            midx[d]  = w;
         end
      end else if (rdy) begin
         mbusy[d] = 1'b0;
         if (mmode[d]) mlast[d] = midx[d];
      end
   endtask

   // Drive one cycle of inputs and advance the model over the next rising edge.
   task automatic cycle(input logic [7:0] r, input bit md, input bit rdy);
      @(negedge clk);
      req8 = r;
      req5 = r[4:0];
      mode = md;
      gnt_ready = rdy;
      model_step(0, r, md, rdy);
      model_step(1, {3'b000, r[4:0]}, md, rdy);
   endtask

   task automatic check_zero();
      chk("rst_valid", 0, 32'(v8), 0);
      chk("rst_idx", 0, 32'(idx8), 0);
      chk("rst_onehot", 0, 32'(oh8), 0);
      chk("rst_busy", 0, 32'(busy8), 0);
      chk("rst_valid", 1, 32'(v5), 0);
      chk("rst_idx", 1, 32'(idx5), 0);
      chk("rst_onehot", 1, 32'(oh5), 0);
      chk("rst_busy", 1, 32'(busy5), 0);
   endtask

   // Assert reset between edges and check outputs clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      req8 = '0; req5 = '0; mode = 1'b0; gnt_ready = 1'b0;
      #1;
      check_zero();
      for (int d = 0; d < 2; d++) begin
         mbusy[d] = 0; mmode[d] = 0; midx[d] = 0; mlast[d] = 0;
      end
      q0.delete(); q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_log(input string name, input int d, input int exp[$]);
      int got[$];
      got = (d == 0) ? glog0 : glog1;
      chk({name, "_count"}, d, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk(name, d, 32'(got[i]), 32'(exp[i]));
   endtask

   task automatic check_dut(input int d);
      logic       v, b;
      logic [2:0] idx;
      logic [7:0] oh;
      int         e;
      v   = (d == 0) ? v8 : v5;
      b   = (d == 0) ? busy8 : busy5;
      idx = (d == 0) ? idx8 : idx5;
      oh  = (d == 0) ? oh8 : {3'b000, oh5};
      chk("gnt_valid", d, 32'(v), 32'(mbusy[d]));
      chk("busy", d, 32'(b), 32'(mbusy[d]));
      if (v && !pv[d]) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_grant dut%0d: got idx %0d expected none", d, idx);
            cur[d] = idx;
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("gnt_idx", d, 32'(idx), 32'(e));
            cur[d] = e;
         end
         if (d == 0) glog0.push_back(int'(idx)); else glog1.push_back(int'(idx));
      end else if (v) begin
         chk("idx_stable", d, 32'(idx), 32'(cur[d]));
      end
      chk("gnt_onehot", d, 32'(oh), v ? (32'd1 << cur[d]) : 32'd0);
      pv[d] = v;
   endtask

   // Monitor: sample just after each rising edge, decoupled from the driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            check_dut(0);
            check_dut(1);
         end else begin
            pv[0] = 0; pv[1] = 0;
         end
      end
   end

   initial begin
      int         e[$];
      logic [7:0] r;
      #1;
      check_zero();
      @(negedge clk);
      rst_n = 1'b1;

      // no requests: nothing granted
      for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b1);

      // fixed priority, grant held 4 cycles before acceptance
      glog0.delete(); glog1.delete();
      for (int i = 0; i < 4; i++) cycle(8'h26, 1'b0, 1'b0);
      cycle(8'h26, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0);
      e = '{5}; chk_log("fix_0x26", 0, e);
      e = '{2}; chk_log("fix_0x26", 1, e);

      // sticky grant after req drops
      glog0.delete(); glog1.delete();
      cycle(8'h10, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, 1'b0);
      cycle(8'h00, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0);
      e = '{4}; chk_log("sticky_0x10", 0, e);
      e = '{4}; chk_log("sticky_0x10", 1, e);

      // round-robin sweep with all requesting
      glog0.delete(); glog1.delete();
      for (int i = 0; i < 18; i++) cycle(8'hFF, 1'b1, 1'b1);
      e = '{7, 6, 5, 4, 3, 2, 1, 0, 7}; chk_log("rr_sweep", 0, e);
      e = '{4, 3, 2, 1, 0, 4, 3, 2, 1}; chk_log("rr_sweep", 1, e);

      // round-robin between the two extremes
      do_reset();
      glog0.delete(); glog1.delete();
      for (int i = 0; i < 8; i++) cycle(8'h81, 1'b1, 1'b1);
      e = '{7, 0, 7, 0}; chk_log("rr_0x81", 0, e);
      e = '{0, 0, 0, 0}; chk_log("rr_0x81", 1, e);

      // reset while granting idx 3, then first RR grant after release
      for (int i = 0; i < 3; i++) cycle(8'h08, 1'b0, 1'b0);
      do_reset();
      glog0.delete(); glog1.delete();
      cycle(8'h0F, 1'b1, 1'b1);
      cycle(8'h0F, 1'b1, 1'b1);
      e = '{3}; chk_log("rr_after_rst", 0, e);
      e = '{3}; chk_log("rr_after_rst", 1, e);

      // randomized traffic with mode/req churn during grants
      for (int i = 0; i < 900; i++) begin
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'h01 << $urandom_range(0, 7);
            default: r = 8'($urandom);
         endcase
         cycle(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
         if (i % 300 == 299) do_reset();
      end

      // drain and confirm nothing was left unmatched
      cycle(8'h00, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      chk("leftover", 0, 32'(q0.size()), 0);
      chk("leftover", 1, 32'(q1.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
